univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal shift register with an automatic N-bit burst shifter. It replaces the fixed 4-bit serial-in/serial-out register in the serial datapath. It supports hold, shift right, shift left and parallel load, and both serial outputs are always visible. A start/busy/done handshake shifts a programmed number of bits without per-cycle control, for use by serializer and deserializer front-ends.

## Interface
Parameters:
- WIDTH, 8: register width in bits, at least 2.
- CNT_W, derived as $clog2(WIDTH+1), local: width of the bit-count field.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sr_in  in  1  serial input entering the MSB on a right shift.
- sl_in  in  1  serial input entering the LSB on a left shift.
- pdata_in  in  WIDTH  parallel load data.
- start  in  1  one-cycle request to begin a burst.
- nbits  in  CNT_W  burst length in bits.
- q  out  WIDTH  register contents.
- sout_r  out  1  q[0], the right-shift serial output (combinational from q).
- sout_l  out  1  q[WIDTH-1], the left-shift serial output.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when a burst completes.

## Operation
- States: IDLE and SHIFT. Outputs after reset: q=0, busy=0, done=0, state IDLE.
- IDLE without an accepted start: mode is applied every edge.
  - Right shift: q <= {sr_in, q[WIDTH-1:1]}.
  - Left shift: q <= {q[WIDTH-2:0], sl_in}.
  - Load: q <= pdata_in.
  - Hold: q unchanged.
- start is accepted only in IDLE and only when mode is 01 or 10.
  - start with mode 00 or 11 is ignored, and mode is applied as normal.
  - start while busy is ignored and has no effect on the running burst.
- Accepted start:
  - Latches the direction from mode.
  - Latches the count as min(nbits, WIDTH).
  - q holds on the start edge.
  - Go to SHIFT, or stay in IDLE and pulse done if the latched count is 0.
- SHIFT:
  - One shift per edge in the latched direction.
  - The serial input is sampled on every shift edge.
  - mode and pdata_in are ignored.
  - The counter decrements on each shift. When it reaches 0, return to IDLE.
- busy = (state == SHIFT), registered.
- done goes high for exactly one cycle after the final shift, or after the start edge when the count is 0.
- Reset has priority over everything:
  - Reset during a burst aborts it: q=0, no done pulse, back to IDLE.
  - Reset coincident with start: start is dropped.
- The count is never allowed to underflow or wrap. The downcounter is CNT_W bits wide, and its terminal value is 0.

## Timing
- Direct modes: q updates on the edge that samples mode, with 1-cycle latency.
- Burst of N ≥ 1 with start sampled at edge k:
  - Shifts occur on edges k+1 through k+N.
  - busy is 1 from after edge k until edge k+N.
  - done is 1 between edge k+N and edge k+N+1.
  - A new start is accepted at the earliest at edge k+N+1, the cycle in which done is high.
- Burst of N = 0 with start at edge k: done is high after edge k, and busy never asserts.
- sout_r and sout_l follow q with no added register stage.

## Structure
- Package shift_pkg:
  - mode_t enum: MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD.
  - state_t enum: ST_IDLE, ST_SHIFT.
  - Shared by the future serializer and deserializer wrappers.
- Single module. No sub-module: the counter and the FSM are small enough to stay inline.

## Test plan
- Reset and load: assert rst, then release. Check q=0, busy=0, done=0. Then mode=11 with pdata_in=8'hA5. Check q=8'hA5 after one edge.
- Free-running shifts: from q=8'hA5, apply right shift with sr_in=1 for one edge. Check q=8'hD2 and sout_r=0. Then left shift with sl_in=0. Check q=8'hA4.
- Right burst: from q=8'hF0, start with mode=01, nbits=3, sr_in=0. Check busy for 3 cycles, q=8'h1E at completion, and a single done pulse.
- Length edge cases:
  - nbits=0: done the cycle after start, busy never high, q unchanged.
  - nbits=12 with WIDTH=8: exactly 8 left shifts with sl_in=1, giving q=8'hFF.
- Ignored and aborted requests:
  - start during busy: ignored, and the burst length is unchanged.
  - start with mode=11: a load is performed and busy stays 0.
  - rst in the middle of a burst: q=0, busy=0, and done is never pulsed.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the universal shift register and its future
// serializer/deserializer wrappers.
package shift_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHR  = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/univ_shift_reg.sv
// Universal shift register (hold / shift right / shift left / load) with an
// automatic burst shifter driven by a start/busy/done handshake.
module univ_shift_reg
   import shift_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic             sr_in,
   input  logic             sl_in,
   input  logic [WIDTH-1:0] pdata_in,
   input  logic             start,
   input  logic [CNT_W-1:0] nbits,
   output logic [WIDTH-1:0] q,
   output logic             sout_r,
   output logic             sout_l,
   output logic             busy,
   output logic             done
);

   state_t           state_q, state_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic             dir_left_q, dir_left_n;
   logic [WIDTH-1:0] q_n;
   logic             done_n;
   mode_t            mode_e;
   logic             start_ok;
   logic [CNT_W-1:0] burst_len;

   assign mode_e    = mode_t'(mode);
   assign start_ok  = start && (mode_e == MODE_SHR || mode_e == MODE_SHL);
   // Requests longer than the register are clamped so the count never exceeds WIDTH.
   assign burst_len = (nbits > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : nbits;

   assign sout_r = q[0];
   assign sout_l = q[WIDTH-1];

   always_comb begin
      state_n    = state_q;
      cnt_n      = cnt_q;
      dir_left_n = dir_left_q;
      q_n        = q;
      done_n     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               dir_left_n = (mode_e == MODE_SHL);
               cnt_n      = burst_len;
               if (burst_len == '0) done_n  = 1'b1;
               else                 state_n = ST_SHIFT;
            end else begin
               case (mode_e)
                  MODE_SHR:  q_n = {sr_in, q[WIDTH-1:1]};
                  MODE_SHL:  q_n = {q[WIDTH-2:0], sl_in};
                  MODE_LOAD: q_n = pdata_in;
                  default:   q_n = q;
               endcase
            end
         end
         ST_SHIFT: begin
            if (dir_left_q) q_n = {q[WIDTH-2:0], sl_in};
            else            q_n = {sr_in, q[WIDTH-1:1]};
            // Saturating decrement: the counter must never wrap below zero.
            cnt_n = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
               state_n = ST_IDLE;
               done_n  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         dir_left_q <= 1'b0;
         q          <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_q    <= state_n;
         cnt_q      <= cnt_n;
         dir_left_q <= dir_left_n;
         q          <= q_n;
         busy       <= (state_n == ST_SHIFT);
         done       <= done_n;
      end
   end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench: directed scenarios plus randomized traffic, all
// compared every cycle against a behavioural model of the register.
module tb_univ_shift_reg;
   import shift_pkg::*;

   localparam int WIDTH = 8;
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       mode;
   logic             sr_in;
   logic             sl_in;
   logic [WIDTH-1:0] pdata_in;
   logic             start;
   logic [CNT_W-1:0] nbits;
   logic [WIDTH-1:0] q;
   logic             sout_r;
   logic             sout_l;
   logic             busy;
   logic             done;

   int checks = 0;
   int errors = 0;

   // Reference model: register value, bits left in the burst, direction, done flag
   logic [WIDTH-1:0] m_q;
   int               m_rem;
   bit               m_left;
   bit               m_done;

   int busy_seen;
   int done_seen;

   univ_shift_reg #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .mode(mode), .sr_in(sr_in), .sl_in(sl_in),
      .pdata_in(pdata_in), .start(start), .nbits(nbits), .q(q),
      .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advances the model by one clock edge from the inputs just applied.
   task automatic modelStep(input logic r, input logic [1:0] m, input logic sr,
                            input logic sl, input logic [WIDTH-1:0] pd,
                            input logic st, input logic [CNT_W-1:0] nb);
      int n;
      if (r) begin
         m_q = '0; m_rem = 0; m_left = 0; m_done = 0;
      end else if (m_rem > 0) begin
         if (m_left) m_q = (m_q << 1) | WIDTH'(sl);
         else        m_q = (m_q >> 1) | (WIDTH'(sr) << (WIDTH - 1));
         m_rem  = m_rem - 1;
         m_done = (m_rem == 0);
      end else begin
         m_done = 0;
         if (st && (m == 2'b01 || m == 2'b10)) begin
            n = int'(nb);
            if (n > WIDTH) n = WIDTH;
            m_left = (m == 2'b10);
            if (n == 0) m_done = 1;
            else        m_rem  = n;
         end else begin
            case (m)
               2'b01:   m_q = (m_q >> 1) | (WIDTH'(sr) << (WIDTH - 1));
               2'b10:   m_q = (m_q << 1) | WIDTH'(sl);
               2'b11:   m_q = pd;
               default: m_q = m_q;
            endcase
         end
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [1:0] m, input logic sr,
                                input logic sl, input logic [WIDTH-1:0] pd,
                                input logic st, input logic [CNT_W-1:0] nb);
      rst = r; mode = m; sr_in = sr; sl_in = sl; pdata_in = pd; start = st; nbits = nb;
      @(posedge clk);
      modelStep(r, m, sr, sl, pd, st, nb);
      #1;
      checkOutput("q", 32'(q), 32'(m_q));
      checkOutput("sout_r", 32'(sout_r), 32'(m_q[0]));
      checkOutput("sout_l", 32'(sout_l), 32'(m_q[WIDTH-1]));
      checkOutput("busy", 32'(busy), 32'(m_rem > 0));
      checkOutput("done", 32'(done), 32'(m_done));
      if (busy) busy_seen++;
      if (done) done_seen++;
   endtask

   initial begin
      m_q = '0; m_rem = 0; m_left = 0; m_done = 0;
      busy_seen = 0; done_seen = 0;

      // Reset and load
      applyStimulus(1, 2'b11, 1, 1, 8'hFF, 1, 4'd3);
      applyStimulus(1, 2'b00, 0, 0, 8'h00, 0, 4'd0);
      applyStimulus(0, 2'b00, 0, 0, 8'h00, 0, 4'd0);
      checkOutput("reset_q", 32'(q), 32'h0);
      checkOutput("reset_busy", 32'(busy), 32'h0);
      checkOutput("reset_done", 32'(done), 32'h0);
      applyStimulus(0, 2'b11, 0, 0, 8'hA5, 0, 4'd0);
      checkOutput("load_a5", 32'(q), 32'hA5);

      // Free-running shifts
      applyStimulus(0, 2'b01, 1, 0, 8'h00, 0, 4'd0);
      checkOutput("shr_d2", 32'(q), 32'hD2);
      checkOutput("shr_sout_r", 32'(sout_r), 32'h0);
      applyStimulus(0, 2'b10, 0, 0, 8'h00, 0, 4'd0);
      checkOutput("shl_a4", 32'(q), 32'hA4);

      // Right burst of 3; mode/pdata during the burst must be ignored
      applyStimulus(0, 2'b11, 0, 0, 8'hF0, 0, 4'd0);
      busy_seen = 0; done_seen = 0;
      applyStimulus(0, 2'b01, 0, 0, 8'h00, 1, 4'd3);
      for (int i = 0; i < 3; i++) applyStimulus(0, 2'b11, 0, 1, 8'h5A, 0, 4'd0);
      checkOutput("burst_r_q", 32'(q), 32'h1E);
      applyStimulus(0, 2'b00, 0, 0, 8'h00, 0, 4'd0);
      checkOutput("burst_r_busy_cycles", 32'(busy_seen), 32'd3);
      checkOutput("burst_r_done_pulses", 32'(done_seen), 32'd1);

      // Zero-length burst
      busy_seen = 0; done_seen = 0;
      applyStimulus(0, 2'b01, 1, 1, 8'h00, 1, 4'd0);
      checkOutput("n0_done", 32'(done), 32'h1);
      checkOutput("n0_q", 32'(q), 32'h1E);
      applyStimulus(0, 2'b00, 0, 0, 8'h00, 0, 4'd0);
      checkOutput("n0_busy_cycles", 32'(busy_seen), 32'd0);

      // Oversized burst is clamped to WIDTH
      applyStimulus(0, 2'b11, 0, 0, 8'h00, 0, 4'd0);
      busy_seen = 0; done_seen = 0;
      applyStimulus(0, 2'b10, 0, 1, 8'h00, 1, 4'd12);
      for (int i = 0; i < 8; i++) applyStimulus(0, 2'b00, 0, 1, 8'h00, 0, 4'd0);
      checkOutput("n12_q", 32'(q), 32'hFF);
      checkOutput("n12_done", 32'(done), 32'h1);
      applyStimulus(0, 2'b00, 0, 0, 8'h00, 0, 4'd0);
      checkOutput("n12_busy_cycles", 32'(busy_seen), 32'd8);

      // Start while busy is ignored
      applyStimulus(0, 2'b11, 0, 0, 8'h81, 0, 4'd0);
      busy_seen = 0; done_seen = 0;
      applyStimulus(0, 2'b01, 0, 0, 8'h00, 1, 4'd4);
      applyStimulus(0, 2'b10, 1, 1, 8'h00, 1, 4'd7);
      for (int i = 0; i < 6; i++) applyStimulus(0, 2'b00, 1, 0, 8'h00, 0, 4'd0);
      checkOutput("restart_busy_cycles", 32'(busy_seen), 32'd4);
      checkOutput("restart_done_pulses", 32'(done_seen), 32'd1);

      // Start with load mode just loads
      applyStimulus(0, 2'b11, 0, 0, 8'h3C, 1, 4'd5);
      checkOutput("start_load_q", 32'(q), 32'h3C);
      checkOutput("start_load_busy", 32'(busy), 32'h0);

      // Reset mid-burst aborts without done
      busy_seen = 0; done_seen = 0;
      applyStimulus(0, 2'b10, 0, 1, 8'h00, 1, 4'd6);
      applyStimulus(0, 2'b00, 0, 1, 8'h00, 0, 4'd0);
      applyStimulus(0, 2'b00, 0, 1, 8'h00, 0, 4'd0);
      applyStimulus(1, 2'b00, 0, 1, 8'h00, 0, 4'd0);
      checkOutput("abort_q", 32'(q), 32'h0);
      checkOutput("abort_busy", 32'(busy), 32'h0);
      for (int i = 0; i < 6; i++) applyStimulus(0, 2'b00, 0, 0, 8'h00, 0, 4'd0);
      checkOutput("abort_done_pulses", 32'(done_seen), 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(63) == 0), 2'($urandom), 1'($urandom), 1'($urandom),
                       WIDTH'($urandom), ($urandom_range(3) == 0), CNT_W'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
